// File: rtl/i2c_txn_ctrl.sv
// I2C transaction sequencer: takes one command and walks the start, byte and stop
// generators through a complete transfer, streaming write data in and read data out.
module i2c_txn_ctrl #(
   parameter int LEN_W    = 8,
   parameter int WDOG_CYC = 100_000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [6:0]       i_cmd_addr,
   input  logic             i_cmd_rw,
   input  logic [LEN_W-1:0] i_cmd_len,
   input  logic [7:0]       i_wdata,
   input  logic             i_wdata_valid,
   output logic             o_wdata_ready,
   output logic [7:0]       o_rdata,
   output logic             o_rdata_valid,
   output logic             o_start_req,
   input  logic             i_start_ready,
   input  logic             i_start_done,
   output logic             o_byte_req,
   input  logic             i_byte_ready,
   input  logic             i_byte_done,
   output logic [7:0]       o_byte_data,
   output logic             o_byte_rd,
   output logic             o_byte_mack,
   input  logic             i_byte_nack,
   input  logic [7:0]       i_byte_rdata,
   output logic             o_stop_req,
   input  logic             i_stop_ready,
   input  logic             i_stop_done,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err_nack,
   output logic             o_err_tmo
);

   localparam int WD_W = $clog2(WDOG_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_WFETCH, S_WBYTE, S_RBYTE, S_STOP, S_DONE
   } state_t;

   state_t            state, state_next;
   logic              req_on;
   logic [WD_W-1:0]   wdog;
   logic [6:0]        addr;
   logic              rw;
   logic [LEN_W-1:0]  rem;
   logic [7:0]        wbyte;

   logic phase_ready, phase_done, in_phase;
   logic accept, waiting, done_ev, expire, enter_phase;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next    = state;
      phase_ready   = 1'b0;
      phase_done    = 1'b0;
      in_phase      = 1'b1;
      o_cmd_ready   = 1'b0;
      o_start_req   = 1'b0;
      o_byte_req    = 1'b0;
      o_stop_req    = 1'b0;
      o_byte_data   = 8'h00;
      o_byte_rd     = 1'b0;
      o_byte_mack   = 1'b0;
      o_wdata_ready = 1'b0;
      o_done        = 1'b0;

      case (state)
         S_IDLE: begin
            in_phase    = 1'b0;
            o_cmd_ready = 1'b1;
         end
         S_START: begin
            phase_ready = i_start_ready;
            phase_done  = i_start_done;
            o_start_req = req_on;
         end
         S_ADDR: begin
            phase_ready = i_byte_ready;
            phase_done  = i_byte_done;
            o_byte_req  = req_on;
            o_byte_data = {addr, rw};
         end
         S_WFETCH: begin
            in_phase      = 1'b0;
            o_wdata_ready = i_wdata_valid;
         end
         S_WBYTE: begin
            phase_ready = i_byte_ready;
            phase_done  = i_byte_done;
            o_byte_req  = req_on;
            o_byte_data = wbyte;
         end
         S_RBYTE: begin
            phase_ready = i_byte_ready;
            phase_done  = i_byte_done;
            o_byte_req  = req_on;
            o_byte_rd   = 1'b1;
            o_byte_mack = (rem != LEN_W'(1));
         end
         S_STOP: begin
            phase_ready = i_stop_ready;
            phase_done  = i_stop_done;
            o_stop_req  = req_on;
         end
         S_DONE: begin
            in_phase = 1'b0;
            o_done   = 1'b1;
         end
         default: in_phase = 1'b0;
      endcase

      // The watchdog only runs once the generator has accepted; done beats expiry.
      accept  = in_phase & req_on & phase_ready;
      waiting = in_phase & ~req_on;
      done_ev = waiting & phase_done;
      expire  = waiting & ~phase_done & (wdog == WD_LAST);

      case (state)
         S_IDLE:   if (i_cmd_valid) state_next = S_START;
         S_START: begin
            if (done_ev)     state_next = S_ADDR;
            else if (expire) state_next = S_STOP;
         end
         S_ADDR: begin
            if (done_ev) begin
               if (i_byte_nack || rem == '0) state_next = S_STOP;
               else if (rw)                 state_next = S_RBYTE;
               else                         state_next = S_WFETCH;
            end else if (expire) begin
               state_next = S_STOP;
            end
         end
         S_WFETCH: if (i_wdata_valid) state_next = S_WBYTE;
         S_WBYTE: begin
            if (done_ev)     state_next = (i_byte_nack || rem == LEN_W'(1)) ? S_STOP : S_WFETCH;
            else if (expire) state_next = S_STOP;
         end
         S_RBYTE: begin
            if (done_ev)     state_next = (rem == LEN_W'(1)) ? S_STOP : S_RBYTE;
            else if (expire) state_next = S_STOP;
         end
         S_STOP:   if (done_ev || expire) state_next = S_DONE;
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase

      // A read byte that loops back into RBYTE still counts as a fresh phase entry.
      enter_phase = (state_next inside {S_START, S_ADDR, S_WBYTE, S_RBYTE, S_STOP}) &&
                    ((state_next != state) || done_ev);
   end

   assign o_busy = (state != S_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         req_on        <= 1'b0;
         wdog          <= '0;
         addr          <= '0;
         rw            <= 1'b0;
         rem           <= '0;
         wbyte         <= '0;
         o_rdata       <= '0;
         o_rdata_valid <= 1'b0;
         o_err_nack    <= 1'b0;
         o_err_tmo     <= 1'b0;
      end else begin
         o_rdata_valid <= 1'b0;

         if (state == S_IDLE && i_cmd_valid) begin
            addr       <= i_cmd_addr;
            rw         <= i_cmd_rw;
            rem        <= i_cmd_len;
            o_err_nack <= 1'b0;
            o_err_tmo  <= 1'b0;
         end

         if (enter_phase)  req_on <= 1'b1;
         else if (accept)  req_on <= 1'b0;

         if (accept)                       wdog <= '0;
         else if (waiting && !phase_done)  wdog <= wdog + WD_W'(1);

         if (o_wdata_ready) wbyte <= i_wdata;

         // Terminal byte is detected at remaining==1, so the guard only stops a wrap.
         if (done_ev && (state == S_WBYTE || state == S_RBYTE) && rem != '0)
            rem <= rem - LEN_W'(1);

         if (done_ev && state == S_RBYTE) begin
            o_rdata       <= i_byte_rdata;
            o_rdata_valid <= 1'b1;
         end

         if (done_ev && i_byte_nack && (state == S_ADDR || state == S_WBYTE))
            o_err_nack <= 1'b1;

         if (expire) o_err_tmo <= 1'b1;
      end
   end

endmodule

// File: tb/tb_i2c_txn_ctrl.sv
// Bench for i2c_txn_ctrl: behavioural generator responders, scoreboard queues filled
// from a transaction-level model, and a monitor that pops and compares on DUT outputs.
module tb_i2c_txn_ctrl;

   localparam int LEN_W = 8;
   localparam int WDOG  = 50;

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_cmd_valid = 1'b0;
   logic             o_cmd_ready;
   logic [6:0]       i_cmd_addr = '0;
   logic             i_cmd_rw = 1'b0;
   logic [LEN_W-1:0] i_cmd_len = '0;
   logic [7:0]       i_wdata = '0;
   logic             i_wdata_valid = 1'b0;
   logic             o_wdata_ready;
   logic [7:0]       o_rdata;
   logic             o_rdata_valid;
   logic             o_start_req;
   logic             i_start_ready = 1'b0;
   logic             i_start_done = 1'b0;
   logic             o_byte_req;
   logic             i_byte_ready = 1'b0;
   logic             i_byte_done = 1'b0;
   logic [7:0]       o_byte_data;
   logic             o_byte_rd;
   logic             o_byte_mack;
   logic             i_byte_nack = 1'b0;
   logic [7:0]       i_byte_rdata = '0;
   logic             o_stop_req;
   logic             i_stop_ready = 1'b0;
   logic             i_stop_done = 1'b0;
   logic             o_busy;
   logic             o_done;
   logic             o_err_nack;
   logic             o_err_tmo;

   i2c_txn_ctrl #(.LEN_W(LEN_W), .WDOG_CYC(WDOG)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_addr(i_cmd_addr), .i_cmd_rw(i_cmd_rw), .i_cmd_len(i_cmd_len),
      .i_wdata(i_wdata), .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready),
      .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
      .o_start_req(o_start_req), .i_start_ready(i_start_ready), .i_start_done(i_start_done),
      .o_byte_req(o_byte_req), .i_byte_ready(i_byte_ready), .i_byte_done(i_byte_done),
      .o_byte_data(o_byte_data), .o_byte_rd(o_byte_rd), .o_byte_mack(o_byte_mack),
      .i_byte_nack(i_byte_nack), .i_byte_rdata(i_byte_rdata),
      .o_stop_req(o_stop_req), .i_stop_ready(i_stop_ready), .i_stop_done(i_stop_done),
      .o_busy(o_busy), .o_done(o_done), .o_err_nack(o_err_nack), .o_err_tmo(o_err_tmo)
   );

   initial forever #5 i_clk = ~i_clk;

   typedef struct { logic [7:0] data; logic rd; logic mack; } byte_exp_t;
   typedef struct { logic nack; logic tmo; int wcnt; } done_exp_t;

   byte_exp_t  exp_bytes[$];
   logic [7:0] exp_rdata[$];
   done_exp_t  exp_done[$];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Transaction under test, shared with the responders.
   logic [7:0] cfg_data [0:255];
   bit         cfg_rw = 1'b0;
   int         cfg_len = 0;
   int         cfg_nack = -1;
   int         cfg_hang = -1;
   bit         cfg_stop_hang = 1'b0;
   int         cmd_seq = 0;
   bit         sb_en = 1'b1;
   bit         aborted = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge i_clk);
      cyc++;
   end

   // Start generator: accepts after a short random delay, then signals done.
   initial begin : start_gen
      forever begin
         @(posedge i_clk); #1;
         if (o_start_req) begin
            repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
            i_start_ready = 1'b1;
            @(posedge i_clk); #1;
            i_start_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
            i_start_done = 1'b1;
            @(posedge i_clk); #1;
            i_start_done = 1'b0;
         end
      end
   end

   // Byte generator: byte 0 is the address, byte k>0 is data byte k-1.
   initial begin : byte_gen
      int idx = 0;
      int seq = -1;
      forever begin
         @(posedge i_clk); #1;
         if (o_byte_req) begin
            repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
            i_byte_ready = 1'b1;
            @(posedge i_clk); #1;
            i_byte_ready = 1'b0;
            if (seq != cmd_seq) begin
               seq = cmd_seq;
               idx = 0;
            end
            if (idx != cfg_hang) begin
               repeat ($urandom_range(0, 4)) begin @(posedge i_clk); #1; end
               i_byte_done  = 1'b1;
               i_byte_nack  = (idx == cfg_nack);
               i_byte_rdata = (idx > 0) ? cfg_data[idx-1] : 8'($urandom);
               @(posedge i_clk); #1;
               i_byte_done = 1'b0;
               i_byte_nack = 1'b0;
            end
            idx++;
         end
      end
   end

   initial begin : stop_gen
      forever begin
         @(posedge i_clk); #1;
         if (o_stop_req) begin
            repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
            i_stop_ready = 1'b1;
            @(posedge i_clk); #1;
            i_stop_ready = 1'b0;
            if (!cfg_stop_hang) begin
               repeat ($urandom_range(0, 3)) begin @(posedge i_clk); #1; end
               i_stop_done = 1'b1;
               @(posedge i_clk); #1;
               i_stop_done = 1'b0;
            end
         end
      end
   end

   initial begin : wdata_feed
      int  wptr = 0;
      int  seq  = 0;
      bit  took = 1'b0;
      forever begin
         @(posedge i_clk); #1;
         if (seq != cmd_seq) begin
            seq  = cmd_seq;
            wptr = 0;
         end else if (took) begin
            wptr++;
         end
         took = 1'b0;
         if (!cfg_rw && wptr < cfg_len && $urandom_range(0, 3) != 0) begin
            i_wdata_valid = 1'b1;
            i_wdata       = cfg_data[wptr];
         end else begin
            i_wdata_valid = 1'b0;
         end
         @(negedge i_clk);
         took = i_wdata_valid && o_wdata_ready;
      end
   end

   // Transaction-level model: what the byte generator should see and how it ends.
   task automatic build_expect(input logic [6:0] addr, input bit rw, input int len,
                               input int nack, input int hang, output bit tmo);
      byte_exp_t b;
      done_exp_t d;
      d.nack = 1'b0; d.tmo = 1'b0; d.wcnt = 0;
      b.data = {addr, rw}; b.rd = 1'b0; b.mack = 1'b0;
      exp_bytes.push_back(b);
      if (hang == 0) d.tmo = 1'b1;
      else if (nack == 0) d.nack = 1'b1;
      else begin
         for (int i = 0; i < len; i++) begin
            if (rw) begin
               b.data = 8'h00; b.rd = 1'b1; b.mack = (i != len - 1);
               exp_bytes.push_back(b);
               if (hang == i + 1) begin d.tmo = 1'b1; break; end
               exp_rdata.push_back(cfg_data[i]);
            end else begin
               b.data = cfg_data[i]; b.rd = 1'b0; b.mack = 1'b0;
               exp_bytes.push_back(b);
               d.wcnt++;
               if (hang == i + 1) begin d.tmo = 1'b1; break; end
               if (nack == i + 1) begin d.nack = 1'b1; break; end
            end
         end
      end
      exp_done.push_back(d);
      tmo = d.tmo;
   endtask

   task automatic apply_stimulus(input logic [6:0] addr, input bit rw, input int len,
                                 input int nack, input int hang);
      bit tmo;
      int n = 0;
      if (aborted) return;
      cfg_rw   = rw;
      cfg_len  = len;
      cfg_nack = nack;
      cfg_hang = hang;
      build_expect(addr, rw, len, nack, hang, tmo);
      cfg_stop_hang = tmo;
      cmd_seq++;
      i_cmd_valid = 1'b1;
      i_cmd_addr  = addr;
      i_cmd_rw    = rw;
      i_cmd_len   = LEN_W'(len);
      @(posedge i_clk); #1;
      // Command stays offered while busy; the DUT must work from its latched copy.
      i_cmd_addr = 7'($urandom);
      i_cmd_rw   = 1'($urandom);
      i_cmd_len  = LEN_W'($urandom);
      while (!o_done && n < 3000) begin
         @(posedge i_clk); #1;
         n++;
      end
      if (!o_done) begin
         check_output("done_timeout", 32'd0, 32'd1);
         aborted = 1'b1;
      end
      i_cmd_valid = 1'b0;
      @(posedge i_clk); #1;
   endtask

   initial begin : monitor
      int        wcnt = 0;
      int        stops = 0;
      int        byte_acc = 0;
      int        stop_acc = 0;
      logic      prev_tmo = 1'b0;
      byte_exp_t eb;
      done_exp_t ed;
      logic [7:0] er;
      forever begin
         @(negedge i_clk);
         if (!sb_en || i_rst) begin
            wcnt = 0; stops = 0; prev_tmo = 1'b0;
            continue;
         end
         if (o_byte_req && i_byte_ready) begin
            byte_acc = cyc + 1;
            if (exp_bytes.size() == 0) check_output("unexpected_byte", 32'd1, 32'd0);
            else begin
               eb = exp_bytes.pop_front();
               check_output("byte_data", 32'(o_byte_data), 32'(eb.data));
               check_output("byte_rd",   32'(o_byte_rd),   32'(eb.rd));
               check_output("byte_mack", 32'(o_byte_mack), 32'(eb.mack));
            end
         end
         if (o_stop_req && i_stop_ready) begin
            stops++;
            stop_acc = cyc + 1;
         end
         if (i_wdata_valid && o_wdata_ready) wcnt++;
         if (o_rdata_valid) begin
            if (exp_rdata.size() == 0) check_output("unexpected_rdata", 32'd1, 32'd0);
            else begin
               er = exp_rdata.pop_front();
               check_output("rdata", 32'(o_rdata), 32'(er));
            end
         end
         if (o_err_tmo && !prev_tmo && exp_done.size() > 0 && exp_done[0].tmo)
            check_output("tmo_latency", 32'(cyc - byte_acc), 32'(WDOG));
         prev_tmo = o_err_tmo;
         if (o_done) begin
            if (exp_done.size() == 0) check_output("unexpected_done", 32'd1, 32'd0);
            else begin
               ed = exp_done.pop_front();
               check_output("err_nack",     32'(o_err_nack), 32'(ed.nack));
               check_output("err_tmo",      32'(o_err_tmo),  32'(ed.tmo));
               check_output("wdata_taken",  32'(wcnt),       32'(ed.wcnt));
               check_output("stop_count",   32'(stops),      32'd1);
               check_output("bytes_left",   32'(exp_bytes.size()), 32'd0);
               check_output("rdata_left",   32'(exp_rdata.size()), 32'd0);
               if (ed.tmo) check_output("stop_tmo_latency", 32'(cyc - stop_acc), 32'(WDOG));
            end
            wcnt = 0;
            stops = 0;
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("[TB] FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "[TB] stopping");
   end

   initial begin : main
      int len, nack, hang, n;
      repeat (3) @(posedge i_clk);
      #1;
      check_output("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
      check_output("rst_busy",      32'(o_busy),      32'd0);
      check_output("rst_reqs",      32'({o_start_req, o_byte_req, o_stop_req}), 32'd0);
      check_output("rst_done",      32'(o_done),      32'd0);
      check_output("rst_errs",      32'({o_err_nack, o_err_tmo}), 32'd0);
      check_output("rst_rvalid",    32'(o_rdata_valid), 32'd0);
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      cfg_data[0] = 8'hA5; cfg_data[1] = 8'h5A;
      apply_stimulus(7'h33, 1'b0, 2, -1, -1);
      cfg_data[0] = 8'h11; cfg_data[1] = 8'h22; cfg_data[2] = 8'h33;
      apply_stimulus(7'h33, 1'b1, 3, -1, -1);
      apply_stimulus(7'h33, 1'b0, 2, 0, -1);
      apply_stimulus(7'h33, 1'b0, 0, -1, -1);
      cfg_data[0] = 8'hC3;
      apply_stimulus(7'h33, 1'b0, 1, -1, 0);
      cfg_data[0] = 8'h01; cfg_data[1] = 8'h02; cfg_data[2] = 8'h03;
      apply_stimulus(7'h12, 1'b0, 3, 2, -1);
      cfg_data[0] = 8'h9E; cfg_data[1] = 8'h7F;
      apply_stimulus(7'h50, 1'b1, 2, 2, -1);

      for (int k = 0; k < 30; k++) begin
         len  = (k == 7) ? 20 : int'($urandom_range(0, 5));
         nack = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
         hang = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len)) : -1;
         for (int i = 0; i < len; i++) cfg_data[i] = 8'($urandom);
         apply_stimulus(7'($urandom), 1'($urandom), len, nack, hang);
      end

      // Abort a 3-byte read mid-RBYTE with reset, unscored until the DUT is idle again.
      if (!aborted) begin
         sb_en = 1'b0;
         cfg_rw = 1'b1; cfg_len = 3; cfg_nack = -1; cfg_hang = -1; cfg_stop_hang = 1'b0;
         cmd_seq++;
         i_cmd_valid = 1'b1; i_cmd_addr = 7'h33; i_cmd_rw = 1'b1; i_cmd_len = LEN_W'(3);
         @(posedge i_clk); #1;
         i_cmd_valid = 1'b0;
         n = 0;
         while (!(o_byte_req && o_byte_rd) && n < 500) begin
            @(posedge i_clk); #1;
            n++;
         end
         check_output("reached_rbyte", 32'(o_byte_req && o_byte_rd), 32'd1);
         i_rst = 1'b1;
         @(posedge i_clk); #1;
         i_rst = 1'b0;
         check_output("abort_reqs",      32'({o_start_req, o_byte_req, o_stop_req}), 32'd0);
         check_output("abort_busy",      32'(o_busy),      32'd0);
         check_output("abort_cmd_ready", 32'(o_cmd_ready), 32'd1);
         repeat (30) @(posedge i_clk);
         #1;
         sb_en = 1'b1;
         @(posedge i_clk); #1;
         cfg_data[0] = 8'h3C; cfg_data[1] = 8'hE1;
         apply_stimulus(7'h21, 1'b0, 2, -1, -1);
      end

      repeat (5) @(posedge i_clk);
      check_output("done_queue_empty", 32'(exp_done.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
